fetch_buffer: RTL and testbench



---
 rtl/fetch_buffer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling queue: accepts up to two instructions per cycle and offers
// decode the oldest one or two. Optional cycle statistics under FETCH_BUF_STAT_EN.
package fetch_buffer_pkg;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } Predict_Branch_S;

  typedef struct packed {
    logic [31:0]     instr;
    logic [31:0]     pc;
    Predict_Branch_S bp;
    logic [4:0]      exc;
    logic            tre;
  } fb_entry_t;

endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [1:0]            if_valid,
  input  logic [63:0]           if_instr,
  input  logic [31:0]           if_pc,
  input  Predict_Branch_S [1:0] if_bp_info,
  input  logic [4:0]            if_exc_code,
  input  logic                  if_tre,
  output logic                  fb_ready,
  input  logic                  allowin_D,
  output logic [1:0]            valid_F,
  output logic [63:0]           instr_F,
  output logic [31:0]           pc_F,
  output Predict_Branch_S [1:0] bp_info_F,
  output logic [4:0]            exc_code_F,
  output logic                  tre_F
`ifdef FETCH_BUF_STAT_EN
  ,
  output logic [31:0]           stat_empty_cyc,
  output logic [31:0]           stat_full_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fb_entry_t        entry_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic [AW-1:0]    head_p1;
  logic [AW-1:0]    tail_p1;
  logic [31:0]      if_pc_p4;
  logic             do_enq;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  fb_entry_t        wr0;
  fb_entry_t        wr1;
  fb_entry_t        head_ent;
  fb_entry_t        next_ent;
  logic             pair_ok;

  assign head_p1  = head_q + AW'(1);
  assign tail_p1  = tail_q + AW'(1);
  assign if_pc_p4 = if_pc + 32'd4;

  // Ready looks only at the registered count so fetch never depends on decode's handshake.
  assign fb_ready = (count_q <= CW'(DEPTH - 2));
  assign do_enq   = fb_ready && (|if_valid);
  assign n_enq    = do_enq ? ({1'b0, if_valid[0]} + {1'b0, if_valid[1]}) : 2'd0;
  assign n_deq    = allowin_D ? ({1'b0, valid_F[0]} + {1'b0, valid_F[1]}) : 2'd0;

  always_comb begin
    wr0       = '0;
    wr1       = '0;
    wr0.exc   = if_exc_code;
    wr0.tre   = if_tre;
    wr1.exc   = if_exc_code;
    wr1.tre   = if_tre;
    wr1.instr = if_instr[63:32];
    wr1.pc    = if_pc_p4;
    wr1.bp    = if_bp_info[1];
    if (if_valid[0]) begin
      wr0.instr = if_instr[31:0];
      wr0.pc    = if_pc;
      wr0.bp    = if_bp_info[0];
    end else begin
      wr0.instr = if_instr[63:32];
      wr0.pc    = if_pc_p4;
      wr0.bp    = if_bp_info[1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (do_enq && !flush) begin
      entry_q[tail_q] <= wr0;
      if (&if_valid) begin
        entry_q[tail_p1] <= wr1;
      end
    end
  end

  always_comb begin
    head_d  = head_q + AW'(n_deq);
    tail_d  = tail_q + AW'(n_enq);
    count_d = count_q + CW'(n_enq) - CW'(n_deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A pair must satisfy decode's implicit pc1 = pc0 + 4 and its shared exception fields.
  assign head_ent = entry_q[head_q];
  assign next_ent = entry_q[head_p1];
  assign pair_ok  = (count_q >= CW'(2)) &&
                    (next_ent.pc == head_ent.pc + 32'd4) &&
                    (next_ent.exc == head_ent.exc) &&
                    (next_ent.tre == head_ent.tre);

  always_comb begin
    if (pair_ok) begin
      valid_F = 2'b11;
    end else if (count_q != '0) begin
      valid_F = 2'b01;
    end else begin
      valid_F = 2'b00;
    end
  end

  assign pc_F         = head_ent.pc;
  assign exc_code_F   = head_ent.exc;
  assign tre_F        = head_ent.tre;
  assign instr_F      = {(valid_F[1] ? next_ent.instr : 32'h0), head_ent.instr};
  assign bp_info_F[0] = head_ent.bp;
  assign bp_info_F[1] = valid_F[1] ? next_ent.bp : '0;

`ifdef FETCH_BUF_STAT_EN
  logic [31:0] stat_empty_q;
  logic [31:0] stat_full_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_empty_q <= '0;
      stat_full_q  <= '0;
    end else begin
      if (count_q == '0) begin
        stat_empty_q <= stat_empty_q + 32'd1;
      end
      if (!fb_ready && (|if_valid)) begin
        stat_full_q <= stat_full_q + 32'd1;
      end
    end
  end

  assign stat_empty_cyc = stat_empty_q;
  assign stat_full_cyc  = stat_full_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed-vector bench for fetch_buffer; checks statistics too when FETCH_BUF_STAT_EN is set.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic                  clk;
  logic                  resetn;
  logic                  flush;
  logic [1:0]            if_valid;
  logic [63:0]           if_instr;
  logic [31:0]           if_pc;
  Predict_Branch_S [1:0] if_bp_info;
  logic [4:0]            if_exc_code;
  logic                  if_tre;
  logic                  fb_ready;
  logic                  allowin_D;
  logic [1:0]            valid_F;
  logic [63:0]           instr_F;
  logic [31:0]           pc_F;
  Predict_Branch_S [1:0] bp_info_F;
  logic [4:0]            exc_code_F;
  logic                  tre_F;
`ifdef FETCH_BUF_STAT_EN
  logic [31:0]           stat_empty_cyc;
  logic [31:0]           stat_full_cyc;
`endif

  fetch_buffer #(.DEPTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_bp_info (if_bp_info),
    .if_exc_code(if_exc_code),
    .if_tre     (if_tre),
    .fb_ready   (fb_ready),
    .allowin_D  (allowin_D),
    .valid_F    (valid_F),
    .instr_F    (instr_F),
    .pc_F       (pc_F),
    .bp_info_F  (bp_info_F),
    .exc_code_F (exc_code_F),
    .tre_F      (tre_F)
`ifdef FETCH_BUF_STAT_EN
    ,
    .stat_empty_cyc(stat_empty_cyc),
    .stat_full_cyc (stat_full_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  ifv;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        tre;
    logic        allow;
    logic [1:0]  ev;
    logic [31:0] epc;
    logic [4:0]  eexc;
    logic        etre;
    logic        erdy;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_empty;
  logic [31:0] exp_full;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  function automatic Predict_Branch_S bp_of(input logic [31:0] pc);
    Predict_Branch_S b;
    b.taken  = pc[3];
    b.target = pc + 32'h80;
    return b;
  endfunction

  function automatic vec_t mk(input logic fl, input logic [1:0] ifv, input logic [31:0] pc,
                              input logic [4:0] exc, input logic tre, input logic allow,
                              input logic [1:0] ev, input logic [31:0] epc,
                              input logic [4:0] eexc, input logic etre, input logic erdy);
    vec_t v;
    v.flush = fl;  v.ifv = ifv;  v.pc = pc;    v.exc = exc;   v.tre = tre;  v.allow = allow;
    v.ev    = ev;  v.epc = epc;  v.eexc = eexc; v.etre = etre; v.erdy = erdy;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic [1:0] ifv, input logic [31:0] pc,
                       input logic [4:0] exc, input logic tre, input logic allow);
    flush       = fl;
    if_valid    = ifv;
    if_pc       = pc;
    if_instr    = {instr_of(pc + 32'd4), instr_of(pc)};
    if_bp_info  = {bp_of(pc + 32'd4), bp_of(pc)};
    if_exc_code = exc;
    if_tre      = tre;
    allowin_D   = allow;
  endtask

  task automatic chk(input string name, input int step, input logic [65:0] got,
                     input logic [65:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, got, want);
    end
  endtask

  task automatic check_outs(input int step, input logic [1:0] ev, input logic [31:0] epc,
                            input logic [4:0] eexc, input logic etre, input logic erdy);
    Predict_Branch_S [1:0] ebp;
    logic [63:0] ein;
    chk("valid_F", step, 66'(valid_F), 66'(ev));
    chk("fb_ready", step, 66'(fb_ready), 66'(erdy));
    if (ev != 2'b00) begin
      ein    = {(ev[1] ? instr_of(epc + 32'd4) : 32'h0), instr_of(epc)};
      ebp[0] = bp_of(epc);
      ebp[1] = ev[1] ? bp_of(epc + 32'd4) : '0;
      chk("pc_F", step, 66'(pc_F), 66'(epc));
      chk("exc_code_F", step, 66'(exc_code_F), 66'(eexc));
      chk("tre_F", step, 66'(tre_F), 66'(etre));
      chk("instr_F", step, 66'(instr_F), 66'(ein));
      chk("bp_info_F", step, bp_info_F, ebp);
    end else begin
      chk("instr_F_hi", step, 66'(instr_F[63:32]), 66'(0));
      chk("bp_info_F_hi", step, 66'(bp_info_F[1]), 66'(0));
    end
  endtask

  initial begin
    // pair through
    vecs[0]  = mk(0, 2'b11, 32'hBFC0_0000, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    vecs[1]  = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'hBFC0_0000, 0, 0, 1);
    vecs[2]  = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    // non-consecutive split
    vecs[3]  = mk(0, 2'b10, 32'h100, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    vecs[4]  = mk(0, 2'b11, 32'h200, 0, 0, 1, 2'b01, 32'h104, 0, 0, 1);
    vecs[5]  = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'h200, 0, 0, 1);
    vecs[6]  = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    // exception split
    vecs[7]  = mk(0, 2'b01, 32'h0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[8]  = mk(0, 2'b01, 32'h4, 4, 1, 0, 2'b01, 32'h0, 0, 0, 1);
    vecs[9]  = mk(0, 2'b00, 0, 0, 0, 1, 2'b01, 32'h0, 0, 0, 1);
    vecs[10] = mk(0, 2'b00, 0, 0, 0, 1, 2'b01, 32'h4, 4, 1, 1);
    vecs[11] = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    // tre-only split, straddling the wrap point
    vecs[12] = mk(0, 2'b01, 32'h300, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[13] = mk(0, 2'b01, 32'h304, 0, 1, 0, 2'b01, 32'h300, 0, 0, 1);
    vecs[14] = mk(0, 2'b00, 0, 0, 0, 1, 2'b01, 32'h300, 0, 0, 1);
    vecs[15] = mk(0, 2'b00, 0, 0, 0, 1, 2'b01, 32'h304, 0, 1, 1);
    // pair with matching nonzero exception fields
    vecs[16] = mk(0, 2'b11, 32'h400, 5, 1, 0, 2'b00, 0, 0, 0, 1);
    vecs[17] = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'h400, 5, 1, 1);
    // fill to full, drop while not ready, drain across the wrap
    vecs[18] = mk(0, 2'b11, 32'h1000, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[19] = mk(0, 2'b11, 32'h1008, 0, 0, 0, 2'b11, 32'h1000, 0, 0, 1);
    vecs[20] = mk(0, 2'b11, 32'h1010, 0, 0, 0, 2'b11, 32'h1000, 0, 0, 1);
    vecs[21] = mk(0, 2'b11, 32'h1018, 0, 0, 0, 2'b11, 32'h1000, 0, 0, 1);
    vecs[22] = mk(0, 2'b11, 32'h1020, 0, 0, 0, 2'b11, 32'h1000, 0, 0, 0);
    vecs[23] = mk(0, 2'b11, 32'h1020, 0, 0, 1, 2'b11, 32'h1000, 0, 0, 0);
    vecs[24] = mk(0, 2'b11, 32'h1020, 0, 0, 1, 2'b11, 32'h1008, 0, 0, 1);
    vecs[25] = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'h1010, 0, 0, 1);
    vecs[26] = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'h1018, 0, 0, 1);
    vecs[27] = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'h1020, 0, 0, 1);
    vecs[28] = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    // flush beats same-cycle enqueue and dequeue
    vecs[29] = mk(0, 2'b11, 32'h2000, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    vecs[30] = mk(0, 2'b11, 32'h2008, 0, 0, 0, 2'b11, 32'h2000, 0, 0, 1);
    vecs[31] = mk(1, 2'b11, 32'h3000, 0, 0, 1, 2'b11, 32'h2000, 0, 0, 1);
    vecs[32] = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    vecs[33] = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    vecs[34] = mk(0, 2'b11, 32'h3000, 0, 0, 1, 2'b00, 0, 0, 0, 1);
    vecs[35] = mk(0, 2'b00, 0, 0, 0, 0, 2'b11, 32'h3000, 0, 0, 1);
    vecs[36] = mk(0, 2'b00, 0, 0, 0, 1, 2'b11, 32'h3000, 0, 0, 1);
    vecs[37] = mk(0, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1);

    exp_empty = 0;
    exp_full  = 0;
    resetn    = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0);

    #12;
    chk("rst_valid_F", -1, 66'(valid_F), 66'(0));
    chk("rst_fb_ready", -1, 66'(fb_ready), 66'(1));
    chk("rst_instr_F", -1, 66'(instr_F), 66'(0));
    chk("rst_pc_F", -1, 66'(pc_F), 66'(0));
    chk("rst_bp_info_F", -1, bp_info_F, 66'(0));
    chk("rst_exc_tre", -1, 66'({exc_code_F, tre_F}), 66'(0));
`ifdef FETCH_BUF_STAT_EN
    chk("rst_stats", -1, 66'({stat_empty_cyc, stat_full_cyc}), 66'(0));
`endif
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_empty = exp_empty + 1;
      chk("idle_valid_F", -2, 66'(valid_F), 66'(0));
      chk("idle_fb_ready", -2, 66'(fb_ready), 66'(1));
    end

    // asynchronous reset mid-operation drops queued entries immediately
    drive(0, 2'b11, 32'h500, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 2'b00, 0, 0, 0, 0);
    check_outs(-3, 2'b11, 32'h500, 0, 0, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid_F", -4, 66'(valid_F), 66'(0));
    chk("arst_fb_ready", -4, 66'(fb_ready), 66'(1));
    chk("arst_pc_F", -4, 66'(pc_F), 66'(0));
    chk("arst_instr_F", -4, 66'(instr_F), 66'(0));
    #2 resetn = 1'b1;
    exp_empty = 0;
    exp_full  = 0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].flush, vecs[i].ifv, vecs[i].pc, vecs[i].exc, vecs[i].tre, vecs[i].allow);
      check_outs(i, vecs[i].ev, vecs[i].epc, vecs[i].eexc, vecs[i].etre, vecs[i].erdy);
      @(posedge clk); #1;
      if (vecs[i].ev == 2'b00) exp_empty = exp_empty + 1;
      if (!vecs[i].erdy && vecs[i].ifv != 2'b00) exp_full = exp_full + 1;
    end

    drive(0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
`ifdef FETCH_BUF_STAT_EN
      chk("stat_empty_cyc", 100 + i, 66'(stat_empty_cyc), 66'(exp_empty));
      chk("stat_full_cyc", 100 + i, 66'(stat_full_cyc), 66'(exp_full));
`endif
      chk("tail_valid_F", 100 + i, 66'(valid_F), 66'(0));
      @(posedge clk); #1;
      exp_empty = exp_empty + 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
